spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have one parameter: HALF_PERIOD, default 2, clk cycles per spi_clk half-period (legal range 1..255).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tx_data  in  8  byte to send, MSB first; sampled only at accept.
REQ-006 tx_valid  in  1  request to send tx_data.
REQ-007 tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready on a rising clk edge.
REQ-008 rx_data  out  8  last byte received from miso; holds its value until the next completion.
REQ-009 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 spi_clk  out  1  SPI serial clock, mode 0 (idle low), registered.
REQ-012 mosi  out  1  serial data out, registered.
REQ-013 miso  in  1  serial data in.
REQ-014 cs  out  1  chip select, active-low, registered.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP; a tick counter SHALL produce one tick every HALF_PERIOD clk cycles in all non-IDLE states and restart on every state entry.
REQ-016 IDLE: cs=1, spi_clk=0, tx_ready=1; on accept, latch tx_data into the tx shift register, drive cs=0 and mosi=tx_data[7], then go to SETUP.
REQ-017 SETUP SHALL last one tick, then go to SHIFT with spi_clk still 0.
REQ-018 SHIFT: spi_clk SHALL toggle on each tick, for exactly 16 toggles (8 rising, 8 falling).
REQ-019 On each rising spi_clk toggle, miso SHALL be shifted into the LSB of the rx shift register on the same clk edge.
REQ-020 On each falling toggle except the 8th, mosi SHALL take the next tx bit; after the 8th falling toggle, go to HOLD with spi_clk=0.
REQ-021 HOLD SHALL last one tick with cs=0; on exit, cs=1, rx_data = rx shift register, rx_valid=1 for one cycle, then go to GAP.
REQ-022 GAP SHALL last one tick with cs=1, then return to IDLE, guaranteeing cs is high for at least HALF_PERIOD+1 cycles between transfers.
REQ-023 rx_valid SHALL rise exactly 18*HALF_PERIOD clk cycles after the accepting edge; cs SHALL be low for exactly 18*HALF_PERIOD cycles.
REQ-024 tx_valid while tx_ready=0 SHALL be ignored, and changes to tx_data after accept SHALL NOT affect the transfer in progress.
REQ-025 If tx_valid is held high continuously, transfers SHALL run back-to-back, each separated by GAP plus one IDLE cycle.
REQ-026 mosi SHALL be 0 whenever cs=1.

Reset
REQ-027 Reset values SHALL be: state=IDLE, cs=1, spi_clk=0, mosi=0, rx_data=0x00, rx_valid=0, busy=0, tx_ready=0 during reset and 1 on the first cycle after it, counters=0.
REQ-028 Reset asserted mid-transfer SHALL abort it on the next edge: cs=1, spi_clk=0, no rx_valid pulse, and rx_data unchanged from 0x00.
REQ-029 Reset SHALL take priority over an accept occurring on the same edge.

Structure
REQ-030 A shared package spi_pkg SHALL hold SPI_WIDTH=8 and the FSM state encoding, for reuse by spi_slave benches.
REQ-031 The tick counter SHALL be a sub-module spi_tick_gen, with inputs clk, reset, enable and restart, output tick, and parameter HALF_PERIOD.
REQ-032 The bit counter SHALL be 4 bits wide and the tick counter $clog2(HALF_PERIOD+1) bits wide; neither SHALL wrap inside a transfer.

Verification
REQ-033 Loopback (miso=mosi), HALF_PERIOD=2, send 0xA5 -> rx_data=0xA5, one rx_valid pulse at cycle 36 after accept, 8 spi_clk rising edges while cs=0.
REQ-034 Slave model returning 0x3C while sending 0xC3 -> mosi bit sequence 1,1,0,0,0,0,1,1 and rx_data=0x3C.
REQ-035 HALF_PERIOD=1, send 0xFF then 0x00 with tx_valid held high -> two transfers, cs high for at least 2 cycles between them, rx_data 0xFF then 0x00.
REQ-036 Reset asserted after the 4th rising spi_clk edge -> cs=1 and spi_clk=0 next cycle, no rx_valid; a following 0x5A transfer completes correctly.
REQ-037 tx_valid pulsed with 0x11 during busy -> ignored, and only the original byte is transmitted.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width and master FSM state encoding.
// Kept separate so spi_slave benches can decode the same state values.
package spi_pkg;
   localparam int SPI_WIDTH = 8;
   localparam int BIT_CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_t;
endpackage

// File: rtl/spi_master_if.sv
// Byte handshake plus serial pins of the SPI master.
// The master modport is the DUT view; slave is the view of whatever drives it.
interface spi_master_if;
   import spi_pkg::*;

   logic [SPI_WIDTH-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [SPI_WIDTH-1:0] rx_data;
   logic                 rx_valid;
   logic                 busy;
   logic                 spi_clk;
   logic                 mosi;
   logic                 miso;
   logic                 cs;

   modport master (
      input  tx_data, tx_valid, miso,
      output tx_ready, rx_data, rx_valid, busy, spi_clk, mosi, cs
   );

   modport slave (
      output tx_data, tx_valid, miso,
      input  tx_ready, rx_data, rx_valid, busy, spi_clk, mosi, cs
   );
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one tick every HALF_PERIOD cycles while enabled,
// restarting from zero whenever restart is high.
module spi_tick_gen #(
   parameter int HALF_PERIOD = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic tick
);
   localparam int CNT_W = $clog2(HALF_PERIOD + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (!enable || restart || cnt_reg == CNT_LAST) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign tick = enable && (cnt_reg == CNT_LAST);
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transfer, MSB first, active-low chip select.
// Frame: SETUP (1 tick), SHIFT (16 spi_clk toggles), HOLD (1 tick), GAP (1 tick).
module spi_master import spi_pkg::*; #(
   parameter int HALF_PERIOD = 2
) (
   input logic          clk,
   input logic          reset,
   spi_master_if.master bus
);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(SPI_WIDTH - 1);

   spi_state_t           state_reg, state_next;
   logic [SPI_WIDTH-2:0] tx_sr_reg, tx_sr_next;
   logic [SPI_WIDTH-1:0] rx_sr_reg, rx_sr_next;
   logic [SPI_WIDTH-1:0] rx_data_reg, rx_data_next;
   logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic                 spi_clk_reg, spi_clk_next;
   logic                 mosi_reg, mosi_next;
   logic                 cs_reg, cs_next;
   logic                 rx_valid_reg, rx_valid_next;
   logic                 tick, tick_en, tick_restart, accept;

   assign bus.tx_ready = (state_reg == IDLE) && !reset;
   assign accept       = bus.tx_valid && bus.tx_ready;
   assign tick_en      = (state_reg != IDLE);
   assign tick_restart = (state_next != state_reg);

   spi_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .enable  (tick_en),
      .restart (tick_restart),
      .tick    (tick)
   );

   always_comb begin
      state_next    = state_reg;
      tx_sr_next    = tx_sr_reg;
      rx_sr_next    = rx_sr_reg;
      rx_data_next  = rx_data_reg;
      bit_cnt_next  = bit_cnt_reg;
      spi_clk_next  = spi_clk_reg;
      mosi_next     = mosi_reg;
      cs_next       = cs_reg;
      rx_valid_next = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (accept) begin
               // MSB goes straight to mosi; the shifter keeps only the rest.
               tx_sr_next   = bus.tx_data[SPI_WIDTH-2:0];
               mosi_next    = bus.tx_data[SPI_WIDTH-1];
               cs_next      = 1'b0;
               bit_cnt_next = '0;
               state_next   = SETUP;
            end
         end
         SETUP: begin
            if (tick) state_next = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               spi_clk_next = !spi_clk_reg;
               if (!spi_clk_reg) begin
                  rx_sr_next = {rx_sr_reg[SPI_WIDTH-2:0], bus.miso};
               end else if (bit_cnt_reg == BIT_LAST) begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  state_next   = HOLD;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  mosi_next    = tx_sr_reg[SPI_WIDTH-2];
                  tx_sr_next   = {tx_sr_reg[SPI_WIDTH-3:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_next       = 1'b1;
               mosi_next     = 1'b0;
               rx_data_next  = rx_sr_reg;
               rx_valid_next = 1'b1;
               state_next    = GAP;
            end
         end
         GAP: begin
            if (tick) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         tx_sr_reg    <= '0;
         rx_sr_reg    <= '0;
         rx_data_reg  <= '0;
         bit_cnt_reg  <= '0;
         spi_clk_reg  <= 1'b0;
         mosi_reg     <= 1'b0;
         cs_reg       <= 1'b1;
         rx_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tx_sr_reg    <= tx_sr_next;
         rx_sr_reg    <= rx_sr_next;
         rx_data_reg  <= rx_data_next;
         bit_cnt_reg  <= bit_cnt_next;
         spi_clk_reg  <= spi_clk_next;
         mosi_reg     <= mosi_next;
         cs_reg       <= cs_next;
         rx_valid_reg <= rx_valid_next;
      end
   end

   assign bus.rx_data  = rx_data_reg;
   assign bus.rx_valid = rx_valid_reg;
   assign bus.busy     = (state_reg != IDLE);
   assign bus.spi_clk  = spi_clk_reg;
   assign bus.mosi     = mosi_reg;
   assign bus.cs       = cs_reg;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: dut_a at HALF_PERIOD=2, dut_b at HALF_PERIOD=1.
module tb_spi_master;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_master_if a_if ();
   spi_master_if b_if ();

   spi_master #(.HALF_PERIOD(2)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
   spi_master #(.HALF_PERIOD(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

   int checks = 0;
   int errors = 0;

   logic       loopback   = 1'b1;
   logic [7:0] slave_byte = 8'h00;
   logic [3:0] a_rise     = 4'd0;
   int         a_rise_tot = 0;
   int         a_rv       = 0;
   logic       a_clk_q    = 1'b0;
   logic [7:0] a_mosi_log = 8'h00;
   int         b_rv       = 0;
   logic       b_cs_q     = 1'b1;
   int         b_hi_run   = 0;
   int         b_last_gap = 0;
   logic [15:0] b_rx_log  = 16'h0000;

   assign a_if.miso = loopback ? a_if.mosi : slave_byte[3'(7 - a_rise)];
   assign b_if.miso = b_if.mosi;

   always @(negedge clk) begin
      a_clk_q <= a_if.spi_clk;
      if (a_if.rx_valid) a_rv <= a_rv + 1;
      if (a_if.cs) begin
         a_rise <= 4'd0;
      end else if (a_if.spi_clk && !a_clk_q) begin
         a_rise     <= a_rise + 4'd1;
         a_rise_tot <= a_rise_tot + 1;
         a_mosi_log <= {a_mosi_log[6:0], a_if.mosi};
      end
      b_cs_q   <= b_if.cs;
      b_hi_run <= b_if.cs ? b_hi_run + 1 : 0;
      if (!b_if.cs && b_cs_q) b_last_gap <= b_hi_run;
      if (b_if.rx_valid) begin
         b_rv     <= b_rv + 1;
         b_rx_log <= {b_rx_log[7:0], b_if.rx_data};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input logic [7:0] d, input bit inject, output int lat);
      int w;
      w = 0;
      do begin @(negedge clk); w++; end while (!a_if.tx_ready && w < 100);
      check("a_ready_wait", 32'(a_if.tx_ready), 1);
      a_if.tx_data  = d;
      a_if.tx_valid = 1'b1;
      @(posedge clk); #1;
      a_if.tx_valid = 1'b0;
      a_if.tx_data  = 8'hEE;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (inject) begin
            a_if.tx_valid = (lat == 10);
            a_if.tx_data  = 8'h11;
         end
      end while (!a_if.rx_valid && lat < 200);
   endtask

   initial begin
      int lat, rv0, r0, w;
      reset = 1'b1;
      a_if.tx_valid = 1'b0; a_if.tx_data = 8'h00;
      b_if.tx_valid = 1'b0; b_if.tx_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs",       32'(a_if.cs), 1);
      check("rst_spi_clk",  32'(a_if.spi_clk), 0);
      check("rst_mosi",     32'(a_if.mosi), 0);
      check("rst_rx_data",  32'(a_if.rx_data), 'h00);
      check("rst_rx_valid", 32'(a_if.rx_valid), 0);
      check("rst_busy",     32'(a_if.busy), 0);
      check("rst_tx_ready", 32'(a_if.tx_ready), 0);
      reset = 1'b0;
      #1;
      check("post_rst_tx_ready", 32'(a_if.tx_ready), 1);

      // loopback 0xA5
      loopback = 1'b1;
      rv0 = a_rv; r0 = a_rise_tot;
      send_a(8'hA5, 1'b0, lat);
      check("a5_latency", lat, 36);
      check("a5_rx_data", 32'(a_if.rx_data), 'hA5);
      repeat (6) @(negedge clk);
      #1;
      check("a5_rv_pulses", a_rv - rv0, 1);
      check("a5_rises",     a_rise_tot - r0, 8);
      check("a5_cs_idle",   32'(a_if.cs), 1);
      check("a5_mosi_idle", 32'(a_if.mosi), 0);

      // slave returns 0x3C while master sends 0xC3
      loopback = 1'b0; slave_byte = 8'h3C;
      send_a(8'hC3, 1'b0, lat);
      check("c3_rx_data",  32'(a_if.rx_data), 'h3C);
      check("c3_mosi_seq", 32'(a_mosi_log), 'hC3);
      repeat (6) @(negedge clk);

      // tx_valid pulsed with 0x11 mid-transfer must be ignored
      loopback = 1'b1;
      rv0 = a_rv;
      send_a(8'h81, 1'b1, lat);
      check("inj_rx_data",  32'(a_if.rx_data), 'h81);
      check("inj_mosi_seq", 32'(a_mosi_log), 'h81);
      repeat (8) @(negedge clk);
      #1;
      check("inj_busy",      32'(a_if.busy), 0);
      check("inj_rv_pulses", a_rv - rv0, 1);

      // dut_b back-to-back 0xFF then 0x00 with tx_valid held high
      rv0 = b_rv;
      @(negedge clk);
      b_if.tx_data = 8'hFF; b_if.tx_valid = 1'b1;
      w = 0;
      while (!b_if.tx_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk);
      @(negedge clk);
      b_if.tx_data = 8'h00;
      w = 0;
      do begin @(negedge clk); w++; end while (!b_if.tx_ready && w < 100);
      check("b2b_second_ready", 32'(b_if.tx_ready), 1);
      @(posedge clk);
      @(negedge clk);
      b_if.tx_valid = 1'b0;
      w = 0;
      while ((b_rv - rv0) < 2 && w < 100) begin @(negedge clk); #1; w++; end
      check("b2b_rv_pulses", b_rv - rv0, 2);
      check("b2b_rx_seq",    32'(b_rx_log), 'hFF00);
      check("b2b_cs_gap",    b_last_gap, 2);
      repeat (4) @(negedge clk);
      check("b2b_busy_end",  32'(b_if.busy), 0);

      // reset after the 4th rising spi_clk edge aborts the transfer
      a_if.tx_data = 8'h96; a_if.tx_valid = 1'b1;
      @(posedge clk); #1;
      a_if.tx_valid = 1'b0;
      w = 0;
      do begin @(negedge clk); #1; w++; end while (a_rise != 4'd4 && w < 100);
      check("abort_rise_wait", 32'(a_rise), 4);
      rv0 = a_rv;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_cs",      32'(a_if.cs), 1);
      check("abort_spi_clk", 32'(a_if.spi_clk), 0);
      check("abort_busy",    32'(a_if.busy), 0);
      check("abort_rx_data", 32'(a_if.rx_data), 'h00);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      check("abort_no_rv",       a_rv - rv0, 0);
      check("abort_rx_data_idle", 32'(a_if.rx_data), 'h00);
      send_a(8'h5A, 1'b0, lat);
      check("5a_latency", lat, 36);
      check("5a_rx_data", 32'(a_if.rx_data), 'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
